// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, FSM states and request record for the data-memory controller
package mem_access_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 33;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_addr_check.sv
// rtl/mem_addr_check.sv - combinational in-range comparator for data-memory word addresses
module mem_addr_check #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 33
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    assign in_range = (32'(addr) < 32'(MEM_DEPTH));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - one-at-a-time load/store controller for the 33-word data memory; MEM_BOUNDS_CHECK_EN adds address range checking
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state;
    state_t            state_nxt;
    mem_req_t          req_q;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_ok;
    logic              accept;

    assign accept = (state == IDLE) && req_valid;

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_q;

    mem_addr_check #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_check (
        .addr     (req_q.addr),
        .in_range (addr_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ISSUE) begin
            err_q <= !addr_ok;
        end
    end

    assign rsp_err = err_q;
`else
    assign addr_ok = 1'b1;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_w is decoded from state so an async reset drops an in-flight store before the next edge
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_w     = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_w = !(req_q.we && addr_ok);
                if (req_q.we || !addr_ok) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The latched request doubles as the memory pin drive, so pins hold between transactions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                req_q.we    <= req_we;
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
            end
            if (state == ISSUE) begin
                rdata_q <= '0;
            end else if (state == CAPT) begin
                rdata_q <= mem_dout;
            end
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_din   = req_q.wdata;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl paired with a behavioural 33x8 memory
module tb_mem_access_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] mem_din;
    logic [7:0] mem_addr;
    logic       mem_w;
    logic [7:0] mem_dout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_din   (mem_din),
        .mem_addr  (mem_addr),
        .mem_w     (mem_w),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:32];

    initial begin
        for (int i = 0; i < 33; i++) mem[i] = 8'(i);
        mem_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (!mem_w) begin
            if (int'(mem_addr) < 33) mem[int'(mem_addr)] <= mem_din;
        end else begin
            mem_dout <= (int'(mem_addr) < 33) ? mem[int'(mem_addr)] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input int hold, input logic [7:0] hold_exp,
                          output logic [7:0] rdata, output logic err,
                          output int lat, output int wlow);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 8'h0E;
        req_wdata = 8'h5A;
        lat  = 1;
        wlow = mem_w ? 0 : 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!mem_w) wlow++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, hold_exp);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         wl;
    logic [7:0] b2b_addr  [3];
    logic [7:0] b2b_wdata [3];
    logic       b2b_we    [3];
    logic [7:0] b2b_exp   [3];
    logic [7:0] b2b_got   [3];
    int         idx;
    int         nrsp;
    int         extra;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_mem_w",     mem_w,     1);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_din",   mem_din,   0);
        rst_n = 1'b1;

        do_req(1'b0, 8'd5, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("ld5_lat", lat, 4);
        check("ld5_rdata", rd, 8'd5);
        check("ld5_err", er, 0);
        check("ld5_wlow", wl, 0);

        do_req(1'b1, 8'd7, 8'hA5, 0, 8'h00, rd, er, lat, wl);
        check("st7_lat", lat, 2);
        check("st7_rdata", rd, 0);
        check("st7_err", er, 0);
        check("st7_wlow", wl, 1);
        do_req(1'b0, 8'd7, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("ld7_rdata", rd, 8'hA5);
        check("ld7_lat", lat, 4);

        do_req(1'b0, 8'd3, 8'h00, 3, 8'd3, rd, er, lat, wl);
        check("ld3_hold_lat", lat, 4);
        check("ld3_hold_rdata", rd, 8'd3);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'd9;
        req_wdata = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_pre_memw", mem_w, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_memw", mem_w, 1);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 8'd9, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("ld9_after_rst", rd, 8'd9);

`ifdef MEM_BOUNDS_CHECK_EN
        do_req(1'b0, 8'd40, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("oob_ld_lat", lat, 2);
        check("oob_ld_err", er, 1);
        check("oob_ld_rdata", rd, 0);
        check("oob_ld_wlow", wl, 0);
        do_req(1'b1, 8'd40, 8'h77, 0, 8'h00, rd, er, lat, wl);
        check("oob_st_lat", lat, 2);
        check("oob_st_err", er, 1);
        check("oob_st_wlow", wl, 0);
        do_req(1'b0, 8'd32, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("edge32_err", er, 0);
        check("edge32_rdata", rd, 8'd32);
`else
        do_req(1'b0, 8'd40, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("oob_ld_lat", lat, 4);
        check("oob_ld_err", er, 0);
        check("oob_mem_addr", mem_addr, 8'd40);
`endif

        b2b_we[0] = 1'b1; b2b_addr[0] = 8'd20; b2b_wdata[0] = 8'h11; b2b_exp[0] = 8'h00;
        b2b_we[1] = 1'b0; b2b_addr[1] = 8'd20; b2b_wdata[1] = 8'h00; b2b_exp[1] = 8'h11;
        b2b_we[2] = 1'b0; b2b_addr[2] = 8'd21; b2b_wdata[2] = 8'h00; b2b_exp[2] = 8'd21;
        idx  = 0;
        nrsp = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && nrsp < 3; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                b2b_got[nrsp] = rsp_rdata;
                nrsp++;
            end
            req_valid = 1'b1;
            if (req_ready && idx < 3) begin
                req_we    = b2b_we[idx];
                req_addr  = b2b_addr[idx];
                req_wdata = b2b_wdata[idx];
                idx++;
            end else begin
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 8'($urandom_range(0, 32));
                req_wdata = 8'($urandom_range(0, 255));
            end
        end
        req_valid = 1'b0;
        check("b2b_rsp_count", nrsp, 3);
        check("b2b_accept_count", idx, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < nrsp) check("b2b_rdata", b2b_got[i], b2b_exp[i]);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        check("b2b_no_extra_rsp", extra, 0);
        do_req(1'b0, 8'd21, 8'h00, 0, 8'h00, rd, er, lat, wl);
        check("b2b_no_stray_write", rd, 8'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
